// File: rtl/rd_sche_port.sv
// rd_sche_port: per-priority tag FIFOs feeding a strict/WRR arbiter and read-data framer.
// Define RD_SCHE_WRR_EN to enable WRR credits, weight registers and iMode.
module rd_sche_port #(
    parameter int         PRI_NUM   = 8,
    parameter int         PRI_DEPTH = 8,
    parameter int         ADDR_W    = 12,
    parameter int         DATA_W    = 32,
    parameter int         WEIGHT_W  = 4,
    parameter logic [3:0] PORT_ID   = 4'd0,
    localparam int        PRI_W     = $clog2(PRI_NUM),
    localparam int        TAG_W     = PRI_W + ADDR_W + 8,
    localparam int        CMD_W     = ADDR_W + 9
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic                iTagVld,
    output logic                oTagRdy,
    input  logic [TAG_W-1:0]    iTagPld,
    output logic                oRdCmdVld,
    input  logic                iRdCmdRdy,
    output logic [CMD_W-1:0]    oRdCmdPld,
    input  logic                iRdDataVld,
    output logic                oRdDataRdy,
    input  logic [DATA_W-1:0]   iRdData,
    input  logic                iRdLast,
    output logic                oRdVld,
    input  logic                iRdRdy,
    output logic [DATA_W-1:0]   oRdData,
    output logic                oRdSop,
    output logic                oRdEop,
    output logic                oRdLast,
    input  logic                iMode,
    input  logic                iWeightLoad,
    input  logic [PRI_W-1:0]    iWeightIdx,
    input  logic [WEIGHT_W-1:0] iWeightPld
);
    localparam int PTR_W = $clog2(PRI_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 4;

    typedef enum logic [1:0] {IDLE, ARB, CMD, DATA} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ENT_W-1:0]   r_mem [PRI_NUM][PRI_DEPTH];
    logic [PTR_W-1:0]   r_wp  [PRI_NUM];
    logic [PTR_W-1:0]   r_rp  [PRI_NUM];
    logic [CNT_W-1:0]   r_cnt [PRI_NUM];
    logic [PRI_NUM-1:0] w_full;
    logic [PRI_NUM-1:0] w_nempty;
    logic [PRI_NUM-1:0] w_push;
    logic [PRI_NUM-1:0] w_pop;
    logic [PRI_W-1:0]   w_tag_pri;
    logic [PRI_W-1:0]   w_sp_idx;
    logic [PRI_W-1:0]   w_pick_idx;
    logic [PRI_W-1:0]   r_sel;
    logic [ENT_W-1:0]   r_ent;
    logic               w_sp_hit;
    logic               w_pick_ok;
    logic               w_latch;
    logic               w_reload;
    logic               w_drop;
    logic               w_in_data;
    logic               r_sop;

    assign w_tag_pri = iTagPld[TAG_W-1 -: PRI_W];
    assign oTagRdy   = iRst_n && !w_full[w_tag_pri];
    assign w_drop    = (r_ent[3:0] == 4'd0);
    assign w_in_data = (r_state == DATA);

    always_comb begin
        for (int q = 0; q < PRI_NUM; q++) begin
            w_full[q]   = (r_cnt[q] == CNT_W'(PRI_DEPTH));
            w_nempty[q] = (r_cnt[q] != '0);
        end
    end

    always_comb begin
        for (int q = 0; q < PRI_NUM; q++) begin
            w_push[q] = iTagVld && oTagRdy && (w_tag_pri == PRI_W'(q));
            w_pop[q]  = (r_state == CMD) && iRdCmdRdy && (r_sel == PRI_W'(q));
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int q = 0; q < PRI_NUM; q++) begin
                r_wp[q]  <= '0;
                r_rp[q]  <= '0;
                r_cnt[q] <= '0;
            end
        end else begin
            for (int q = 0; q < PRI_NUM; q++) begin
                if (w_push[q]) r_wp[q] <= r_wp[q] + 1'b1;
                if (w_pop[q])  r_rp[q] <= r_rp[q] + 1'b1;
                if (w_push[q] && !w_pop[q])
                    r_cnt[q] <= r_cnt[q] + 1'b1;
                else if (!w_push[q] && w_pop[q])
                    r_cnt[q] <= r_cnt[q] - 1'b1;
            end
        end
    end

    // Storage needs no reset; validity is tracked by the counters.
    always_ff @(posedge iClk) begin
        for (int q = 0; q < PRI_NUM; q++)
            if (w_push[q]) r_mem[q][r_wp[q]] <= iTagPld[ENT_W+3:4];
    end

    always_comb begin
        w_sp_hit = 1'b0;
        w_sp_idx = '0;
        for (int q = 0; q < PRI_NUM; q++) begin
            if (w_nempty[q]) begin
                w_sp_hit = 1'b1;
                w_sp_idx = PRI_W'(q);
            end
        end
    end

`ifdef RD_SCHE_WRR_EN
    logic [WEIGHT_W-1:0] r_weight [PRI_NUM];
    logic [WEIGHT_W-1:0] r_credit [PRI_NUM];
    logic                w_wrr_hit;
    logic [PRI_W-1:0]    w_wrr_idx;
    logic                w_unused;

    assign w_unused = ^iTagPld[3:0];

    always_comb begin
        w_wrr_hit = 1'b0;
        w_wrr_idx = '0;
        for (int q = 0; q < PRI_NUM; q++) begin
            if (w_nempty[q] && r_credit[q] != '0) begin
                w_wrr_hit = 1'b1;
                w_wrr_idx = PRI_W'(q);
            end
        end
        w_pick_ok  = iMode ? w_wrr_hit : w_sp_hit;
        w_pick_idx = iMode ? w_wrr_idx : w_sp_idx;
    end

    // A zero weight reloads as one so a queue can never starve forever.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int q = 0; q < PRI_NUM; q++) begin
                r_weight[q] <= '1;
                r_credit[q] <= '1;
            end
        end else begin
            if (iWeightLoad) r_weight[iWeightIdx] <= iWeightPld;
            for (int q = 0; q < PRI_NUM; q++) begin
                if (w_reload)
                    r_credit[q] <= (r_weight[q] == '0) ?
                                   WEIGHT_W'(1) : r_weight[q];
                else if (w_latch && iMode && w_pick_idx == PRI_W'(q))
                    r_credit[q] <= r_credit[q] - WEIGHT_W'(1);
            end
        end
    end
`else
    logic w_unused;

    assign w_pick_ok  = w_sp_hit;
    assign w_pick_idx = w_sp_idx;
    assign w_unused   = ^{iTagPld[3:0], iMode, iWeightLoad,
                          iWeightIdx, iWeightPld, w_reload};
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_reload    = 1'b0;
        unique case (r_state)
            IDLE: if (|w_nempty) w_state_nxt = ARB;
            ARB: begin
                if (w_pick_ok) begin
                    w_latch     = 1'b1;
                    w_state_nxt = CMD;
                end else begin
                    w_reload = 1'b1;
                end
            end
            CMD:  if (iRdCmdRdy) w_state_nxt = w_drop ? IDLE : DATA;
            DATA: if (iRdDataVld && iRdRdy && iRdLast) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_sel <= '0;
            r_ent <= '0;
            r_sop <= 1'b0;
        end else begin
            if (w_latch) begin
                r_sel <= w_pick_idx;
                r_ent <= r_mem[w_pick_idx][r_rp[w_pick_idx]];
            end
            if (r_state == CMD && iRdCmdRdy && !w_drop)
                r_sop <= 1'b1;
            else if (w_in_data && iRdDataVld && iRdRdy)
                r_sop <= 1'b0;
        end
    end

    assign oRdCmdVld  = (r_state == CMD);
    assign oRdCmdPld  = oRdCmdVld ? {r_ent, PORT_ID, w_drop} : '0;
    assign oRdVld     = w_in_data && iRdDataVld;
    assign oRdDataRdy = w_in_data && iRdRdy;
    assign oRdData    = w_in_data ? iRdData : '0;
    assign oRdSop     = w_in_data && r_sop;
    assign oRdEop     = w_in_data && iRdLast;
    assign oRdLast    = w_in_data && iRdLast;
endmodule

// File: tb/tb_rd_sche_port.sv
// Scoreboard bench for rd_sche_port: directed tags, memory responder, cmd/data monitors.
// Expected order for the WRR scenario depends on RD_SCHE_WRR_EN.
module tb_rd_sche_port;
    localparam logic [3:0] PID = 4'd5;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iTagVld = 1'b0;
    logic        oTagRdy;
    logic [22:0] iTagPld = '0;
    logic        oRdCmdVld;
    logic        iRdCmdRdy = 1'b0;
    logic [20:0] oRdCmdPld;
    logic        iRdDataVld = 1'b0;
    logic        oRdDataRdy;
    logic [31:0] iRdData = '0;
    logic        iRdLast = 1'b0;
    logic        oRdVld;
    logic        iRdRdy = 1'b0;
    logic [31:0] oRdData;
    logic        oRdSop;
    logic        oRdEop;
    logic        oRdLast;
    logic        iMode = 1'b0;
    logic        iWeightLoad = 1'b0;
    logic [2:0]  iWeightIdx = '0;
    logic [3:0]  iWeightPld = '0;

    int checks = 0;
    int failures = 0;
    logic [20:0] exp_cmd [$];
    logic [33:0] exp_dat [$];

    rd_sche_port #(
        .PRI_NUM(8), .PRI_DEPTH(8), .ADDR_W(12),
        .DATA_W(32), .WEIGHT_W(4), .PORT_ID(PID)
    ) dut (
        .iClk(iClk), .iRst_n(iRst_n),
        .iTagVld(iTagVld), .oTagRdy(oTagRdy), .iTagPld(iTagPld),
        .oRdCmdVld(oRdCmdVld), .iRdCmdRdy(iRdCmdRdy),
        .oRdCmdPld(oRdCmdPld),
        .iRdDataVld(iRdDataVld), .oRdDataRdy(oRdDataRdy),
        .iRdData(iRdData), .iRdLast(iRdLast),
        .oRdVld(oRdVld), .iRdRdy(iRdRdy), .oRdData(oRdData),
        .oRdSop(oRdSop), .oRdEop(oRdEop), .oRdLast(oRdLast),
        .iMode(iMode), .iWeightLoad(iWeightLoad),
        .iWeightIdx(iWeightIdx), .iWeightPld(iWeightPld)
    );

    always #5 iClk = ~iClk;

    function automatic logic [31:0] mk_data(logic [11:0] a, logic [3:0] b);
        return {8'hA5, a, 8'h3C, b};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic expect_pkt(input logic [11:0] a, input logic [3:0] len);
        exp_cmd.push_back({a, len, PID, len == 4'd0});
        for (int b = 0; b < int'(len); b++)
            exp_dat.push_back({mk_data(a, 4'(b)), b == 0, b == int'(len) - 1});
    endtask

    task automatic push_tag(input logic [2:0] p, input logic [11:0] a,
                            input logic [3:0] len);
        iTagVld = 1'b1;
        iTagPld = {p, a, len, 4'h9};
        @(negedge iClk);
        chk("tag_rdy", oTagRdy, 1'b1);
        @(posedge iClk); #1;
        iTagVld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_cmd.size() != 0 || exp_dat.size() != 0) && n < 3000) begin
            @(posedge iClk); #1;
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL drain_timeout cmd_left=%0d dat_left=%0d",
                     exp_cmd.size(), exp_dat.size());
        end
        repeat (3) begin @(posedge iClk); #1; end
    endtask

    // Monitors: command and egress beats popped against the scoreboard.
    always @(negedge iClk) begin
        if (iRst_n) begin
            if (oRdCmdVld && iRdCmdRdy) begin
                if (exp_cmd.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cmd_unexpected got=%h want=none", oRdCmdPld);
                end else begin
                    chk("cmd", oRdCmdPld, exp_cmd.pop_front());
                end
            end
            if (oRdVld) chk("data_rdy_follow", oRdDataRdy, iRdRdy);
            if (oRdVld && iRdRdy) begin
                if (exp_dat.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected got=%h want=none", oRdData);
                end else begin
                    logic [33:0] e;
                    e = exp_dat.pop_front();
                    chk("beat", {oRdData, oRdSop, oRdEop, oRdLast}, {e, e[0]});
                end
            end
        end
    end

    // Packet memory model: answers each non-drop command with len beats.
    initial begin
        logic [11:0] a;
        logic [3:0]  len;
        forever begin
            @(negedge iClk);
            if (iRst_n && oRdCmdVld && iRdCmdRdy && !oRdCmdPld[0]) begin
                a   = oRdCmdPld[20:9];
                len = oRdCmdPld[8:5];
                @(posedge iClk); #1;
                for (int b = 0; b < int'(len); b++) begin
                    iRdDataVld = 1'b1;
                    iRdData    = mk_data(a, 4'(b));
                    iRdLast    = (b == int'(len) - 1);
                    @(negedge iClk);
                    while (!oRdDataRdy) @(negedge iClk);
                    @(posedge iClk); #1;
                end
                iRdDataVld = 1'b0;
                iRdLast    = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord [12];
        int i7, i0;
        // Reset: outputs stay low even with live-looking inputs.
        iTagPld = 23'h7FFFFF;
        iRdRdy  = 1'b1;
        repeat (5) @(negedge iClk);
        chk("rst_ctrl", {oTagRdy, oRdCmdVld, oRdCmdPld, oRdDataRdy,
                         oRdVld, oRdSop, oRdEop, oRdLast}, '0);
        chk("rst_data", oRdData, '0);
        @(posedge iClk); #1;
        iRst_n = 1'b1;
        for (int p = 0; p < 8; p++) begin
            iTagPld = {3'(p), 20'h0};
            @(negedge iClk);
            chk("rdy_after_rst", oTagRdy, 1'b1);
        end
        @(posedge iClk); #1;

        // Drop tag and tag-to-command latency.
        iRdCmdRdy = 1'b1;
        expect_pkt(12'h440, 4'd0);
        push_tag(3'd4, 12'h440, 4'd0);
        @(negedge iClk);
        chk("lat_idle", oRdCmdVld, 1'b0);
        @(negedge iClk);
        chk("lat_arb", oRdCmdVld, 1'b0);
        @(negedge iClk);
        chk("lat_cmd", oRdCmdVld, 1'b1);
        @(negedge iClk);
        chk("drop_idle", {oRdCmdVld, oRdDataRdy, oRdVld}, 3'b000);
        @(posedge iClk); #1;
        drain();

        // Strict priority: pri1 holds CMD while 0,3,7 queue up.
        iRdCmdRdy = 1'b0;
        expect_pkt(12'h110, 4'd4);
        expect_pkt(12'h170, 4'd4);
        expect_pkt(12'h130, 4'd4);
        expect_pkt(12'h100, 4'd4);
        push_tag(3'd1, 12'h110, 4'd4);
        push_tag(3'd0, 12'h100, 4'd4);
        push_tag(3'd3, 12'h130, 4'd4);
        push_tag(3'd7, 12'h170, 4'd4);
        iRdCmdRdy = 1'b1;
        drain();

        // Full queue on pri 2; a pop in the same cycle does not admit a tag.
        iRdCmdRdy = 1'b0;
        for (int k = 0; k < 8; k++) expect_pkt(12'h200 + 12'(k), 4'd2);
        for (int k = 0; k < 8; k++) push_tag(3'd2, 12'h200 + 12'(k), 4'd2);
        iTagPld = {3'd2, 12'h2FF, 4'd2, 4'h0};
        @(negedge iClk);
        chk("full_pri2", oTagRdy, 1'b0);
        @(posedge iClk); #1;
        iTagPld = {3'd3, 12'h3FF, 4'd2, 4'h0};
        @(negedge iClk);
        chk("full_pri3", oTagRdy, 1'b1);
        @(posedge iClk); #1;
        iTagPld   = {3'd2, 12'h2FF, 4'd2, 4'h0};
        iTagVld   = 1'b1;
        iRdCmdRdy = 1'b1;
        @(posedge iClk); #1;
        iTagVld   = 1'b0;
        iRdCmdRdy = 1'b0;
        @(negedge iClk);
        chk("full_pop_rdy", oTagRdy, 1'b1);
        @(posedge iClk); #1;
        iRdCmdRdy = 1'b1;
        drain();

        // Egress backpressure over an 8-beat packet.
        expect_pkt(12'h6A0, 4'd8);
        push_tag(3'd6, 12'h6A0, 4'd8);
        repeat (30) begin
            iRdRdy = ~iRdRdy;
            @(posedge iClk); #1;
        end
        iRdRdy = 1'b1;
        drain();

        // WRR weights 7=2, 0=1; drain pri7 credits first so a reload aligns them.
        iMode       = 1'b1;
        iWeightLoad = 1'b1;
        iWeightIdx  = 3'd7;
        iWeightPld  = 4'd2;
        @(posedge iClk); #1;
        iWeightIdx  = 3'd0;
        iWeightPld  = 4'd1;
        @(posedge iClk); #1;
        iWeightLoad = 1'b0;
        for (int k = 0; k < 15; k++) begin
            expect_pkt(12'h7E0 + 12'(k), 4'd0);
            push_tag(3'd7, 12'h7E0 + 12'(k), 4'd0);
            drain();
        end
`ifdef RD_SCHE_WRR_EN
        ord = '{7, 7, 0, 7, 7, 0, 7, 7, 0, 0, 0, 0};
`else
        ord = '{7, 7, 7, 7, 7, 7, 0, 0, 0, 0, 0, 0};
`endif
        i7 = 0;
        i0 = 0;
        for (int k = 0; k < 12; k++) begin
            if (ord[k] == 7) begin
                expect_pkt(12'h700 + 12'(i7), 4'd1);
                i7++;
            end else begin
                expect_pkt(12'h0A0 + 12'(i0), 4'd1);
                i0++;
            end
        end
        iRdCmdRdy = 1'b0;
        for (int k = 0; k < 6; k++) push_tag(3'd7, 12'h700 + 12'(k), 4'd1);
        for (int k = 0; k < 6; k++) push_tag(3'd0, 12'h0A0 + 12'(k), 4'd1);
        iRdCmdRdy = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
